// File: rtl/alu_cmd_sequencer.sv
// Register-indexed ALU command front-end: reads operands, issues to the ALU, writes the result back.
// Latency: accept edge T, alu_enable in T+1, writeback/done in T+1+ALU_LAT, ready again T+2+ALU_LAT.
// Backpressure: cmd_ready is low while a command is in flight (no queueing); ld port never stalls.
// Optional opcode legality check is compiled in with ALU_CMD_OPCHECK_EN.
module alu_cmd_sequencer #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 8,
    parameter int ALU_LAT = 1,
    localparam int RW     = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [RW-1:0]     cmd_rd,
    input  logic [RW-1:0]     cmd_ra,
    input  logic [RW-1:0]     cmd_rb,
    input  logic              ld_en,
    input  logic [RW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [RW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              done,
    output logic              zero_flag,
    output logic              illegal
);

    // Wait counter only has to hold ALU_LAT-1.
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       wait_cnt;
    logic [CW-1:0]       wait_dec;
    logic [RW-1:0]       rd_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                zero_q;
    logic                illegal_q;
    logic                op_legal;
    logic                accept;
    logic                issue_go;
    logic                wb_we;
    logic [DATA_W-1:0]   regs [REG_CNT];

    assign cmd_ready = (state == S_IDLE) & resetn;
    assign accept    = cmd_valid & cmd_ready;
    assign issue_go  = accept & op_legal;
    assign wb_we     = (state == S_WB);
    assign wait_dec  = wait_cnt - CW'(1);

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign alu_enable = (state == S_ISSUE);
    assign done       = wb_we;
    assign zero_flag  = zero_q;
    assign illegal    = illegal_q;
    assign rd_data    = rd_data_q;

    // Opcode legality decode; every opcode is legal when the check is compiled out.
    always_comb begin
        op_legal = 1'b0;
`ifdef ALU_CMD_OPCHECK_EN
        case (cmd_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
`else
        op_legal = 1'b1;
`endif
    end

    // Next-state logic: IDLE -> ISSUE -> (WAIT)* -> WB -> IDLE; illegal commands stay in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue_go) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (ALU_LAT == 1) ? S_WB : S_WAIT;
            S_WAIT:  if (wait_dec == '0) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= CW'(ALU_LAT - 1);
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_dec;
        end
    end

    // Operand/opcode capture at accept; a same-cycle ld to ra/rb is forwarded so the new value is used.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            rd_q <= '0;
        end else if (issue_go) begin
            a_q  <= (ld_en && (ld_addr == cmd_ra)) ? ld_data : regs[cmd_ra];
            b_q  <= (ld_en && (ld_addr == cmd_rb)) ? ld_data : regs[cmd_rb];
            op_q <= cmd_op;
            rd_q <= cmd_rd;
        end
    end

    // Status flags: zero captured at writeback, illegal pulses the cycle after a rejected accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (wb_we) begin
                zero_q <= alu_zero;
            end
            illegal_q <= accept & ~op_legal;
        end
    end

    // Register file: ld and writeback both write; writeback is last so it wins on the same index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (wb_we) begin
                regs[rd_q] <= alu_out;
            end
        end
    end

    // Readback register; forwards writes landing on the same edge with the same priority as the file.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_q <= '0;
        end else if (wb_we && (rd_q == rd_addr)) begin
            rd_data_q <= alu_out;
        end else if (ld_en && (ld_addr == rd_addr)) begin
            rd_data_q <= ld_data;
        end else begin
            rd_data_q <= regs[rd_addr];
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    localparam logic [31:0] GARB = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid1, cmd_valid3;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  rd_addr;

    logic        cmd_ready1, alu_enable1, done1, zero_flag1, illegal1, alu_zero1;
    logic [31:0] rd_data1, alu_a1, alu_b1, alu_out1;
    logic [3:0]  alu_op1;
    logic        cmd_ready3, alu_enable3, done3, zero_flag3, illegal3, alu_zero3;
    logic [31:0] rd_data3, alu_a3, alu_b3, alu_out3;
    logic [3:0]  alu_op3;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 models the ALU_LAT=1 instance, index 1 the ALU_LAT=3 instance.
    logic [31:0] mdl_r [2][8];
    logic        mdl_z [2];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DATA_W(32), .REG_CNT(8), .ALU_LAT(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
        .rd_data(rd_data1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_enable(alu_enable1), .alu_out(alu_out1), .alu_zero(alu_zero1),
        .done(done1), .zero_flag(zero_flag1), .illegal(illegal1)
    );

    alu_cmd_sequencer #(.DATA_W(32), .REG_CNT(8), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
        .rd_data(rd_data3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
        .alu_enable(alu_enable3), .alu_out(alu_out3), .alu_zero(alu_zero3),
        .done(done3), .zero_flag(zero_flag3), .illegal(illegal3)
    );

    // Behavioural ALU: the result function both DUTs see.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return $signed(a) >>> b[4:0];
            4'd12:   return {31'd0, $signed(a) < $signed(b)};
            4'd13:   return {31'd0, a < b};
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic bit tb_legal(input logic [3:0] op);
`ifdef ALU_CMD_OPCHECK_EN
        return (op <= 4'd4) || (op >= 4'd8 && op <= 4'd10) || op == 4'd12 || op == 4'd13;
`else
        return 1'b1;
`endif
    endfunction

    // ALU stand-ins: result valid exactly ALU_LAT edges after the enable cycle, garbage otherwise.
    logic [31:0] res1;
    logic        vld1;
    logic [31:0] res3 [3];
    logic        vld3 [3];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res1 <= '0;
            vld1 <= 1'b0;
        end else begin
            res1 <= alu_f(alu_op1, alu_a1, alu_b1);
            vld1 <= alu_enable1;
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                res3[i] <= '0;
                vld3[i] <= 1'b0;
            end
        end else begin
            res3[0] <= alu_f(alu_op3, alu_a3, alu_b3);
            vld3[0] <= alu_enable3;
            for (int i = 1; i < 3; i++) begin
                res3[i] <= res3[i-1];
                vld3[i] <= vld3[i-1];
            end
        end
    end

    assign alu_out1  = vld1 ? res1 : GARB;
    assign alu_zero1 = vld1 ? (res1 == 32'd0) : 1'b1;
    assign alu_out3  = vld3[2] ? res3[2] : GARB;
    assign alu_zero3 = vld3[2] ? (res3[2] == 32'd0) : 1'b1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // {alu_enable, done, illegal, cmd_ready}
    function automatic logic [3:0] ctl_of(input int which);
        if (which == 1) return {alu_enable1, done1, illegal1, cmd_ready1};
        return {alu_enable3, done3, illegal3, cmd_ready3};
    endfunction

    task automatic set_ref(input logic [2:0] a, input logic [31:0] v);
        mdl_r[0][a] = v;
        mdl_r[1][a] = v;
    endtask

    task automatic clear_ref();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mdl_r[d][i] = '0;
            mdl_z[d] = 1'b0;
        end
    endtask

    // Called and returns at a negedge.
    task automatic ld_reg(input logic [2:0] a, input logic [31:0] v);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(negedge clk);
        ld_en = 1'b0;
        set_ref(a, v);
    endtask

    task automatic readback(input logic [2:0] a);
        rd_addr = a;
        @(negedge clk);
        chk($sformatf("rd1_r%0d", a), {32'd0, rd_data1}, {32'd0, mdl_r[0][a]});
        chk($sformatf("rd3_r%0d", a), {32'd0, rd_data3}, {32'd0, mdl_r[1][a]});
    endtask

    // One command on the chosen instance with per-cycle checks. ld_k<0: no ld;
    // ld_k==0: ld in the accept cycle; ld_k>=1: ld active at the closing edge of cycle T+ld_k.
    task automatic run_cmd(input int which, input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] ra, input logic [2:0] rb,
                           input int ld_k, input logic [2:0] la, input logic [31:0] ldd);
        int lat, d, guard;
        bit legal, ez;
        logic [31:0] av, bv, res, ga, gb;
        logic [3:0]  ctl, ectl, gop;
        lat   = (which == 1) ? 1 : 3;
        d     = (which == 1) ? 0 : 1;
        legal = tb_legal(op);
        guard = 0;
        ctl   = ctl_of(which);
        while (ctl[0] == 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
            ctl = ctl_of(which);
        end
        chk("ready_wait", {63'd0, ctl[0]}, 64'd1);
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        if (which == 1) cmd_valid1 = 1'b1; else cmd_valid3 = 1'b1;
        if (ld_k == 0) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ldd;
        end
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0;
        cmd_valid3 = 1'b0;
        ld_en      = 1'b0;
        if (ld_k == 0) set_ref(la, ldd);
        av  = mdl_r[d][ra];
        bv  = mdl_r[d][rb];
        res = alu_f(op, av, bv);
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            ld_en   = 1'b0;
            ectl[3] = legal && (k == 1);
            ectl[2] = legal && (k == lat + 1);
            ectl[1] = !legal && (k == 1);
            ectl[0] = legal ? (k >= lat + 2) : 1'b1;
            ctl     = ctl_of(which);
            chk($sformatf("ctl_dut%0d_op%h_k%0d", which, op, k), {60'd0, ctl}, {60'd0, ectl});
            if (legal && (k == 1 || k == lat + 1)) begin
                ga  = (which == 1) ? alu_a1  : alu_a3;
                gb  = (which == 1) ? alu_b1  : alu_b3;
                gop = (which == 1) ? alu_op1 : alu_op3;
                chk($sformatf("alu_a_k%0d", k), {32'd0, ga}, {32'd0, av});
                chk($sformatf("alu_b_k%0d", k), {32'd0, gb}, {32'd0, bv});
                chk($sformatf("alu_op_k%0d", k), {60'd0, gop}, {60'd0, op});
            end
            if (k == lat + 2) begin
                ez = legal ? (res == 32'd0) : mdl_z[d];
                chk("zero_flag", {63'd0, (which == 1) ? zero_flag1 : zero_flag3}, {63'd0, ez});
            end
            if (ld_k == k) begin
                ld_en = 1'b1; ld_addr = la; ld_data = ldd;
                set_ref(la, ldd);
            end
        end
        ld_en = 1'b0;
        if (legal) begin
            mdl_r[d][rd] = res;
            mdl_z[d]     = (res == 32'd0);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, ra, rb;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lk, w;
        logic [3:0]  op;
        logic [2:0]  rd, ra, rb, la;

        tbl[0] = '{4'd0, 3'd3, 3'd1, 3'd2, 32'h4B9E_3508, 1'b0};
        tbl[1] = '{4'd1, 3'd4, 3'd1, 3'd2, 32'hE245_E2C2, 1'b0};
        tbl[2] = '{4'd2, 3'd5, 3'd1, 3'd2, 32'h94A0_0921, 1'b0};
        tbl[3] = '{4'd1, 3'd6, 3'd1, 3'd1, 32'h0000_0000, 1'b1};
        tbl[4] = '{4'd3, 3'd7, 3'd1, 3'd2, 32'hB6FE_2BE7, 1'b0};

        resetn = 1'b0;
        cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        clear_ref();

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_ctl1", {60'd0, ctl_of(1)}, 64'd0);
        chk("rst_ctl3", {60'd0, ctl_of(3)}, 64'd0);
        chk("rst_misc1", {zero_flag1, alu_op1, rd_data1, alu_a1 | alu_b1}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rel_ctl1", {60'd0, ctl_of(1)}, 64'd1);
        chk("rel_ctl3", {60'd0, ctl_of(3)}, 64'd1);

        // Directed vectors.
        ld_reg(3'd1, 32'h96F2_0BE5);
        ld_reg(3'd2, 32'hB4AC_2923);
        for (int i = 0; i < 5; i++) begin
            run_cmd(1, tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, -1, 3'd0, 32'd0);
            readback(tbl[i].rd);
            chk($sformatf("tbl%0d_res", i), {32'd0, rd_data1}, {32'd0, tbl[i].exp_res});
            chk($sformatf("tbl%0d_zero", i), {63'd0, zero_flag1}, {63'd0, tbl[i].exp_zero});
        end

        // Opcode 1111: rejected when the check is built in, otherwise issued normally.
        run_cmd(1, 4'hF, 3'd3, 3'd1, 3'd2, -1, 3'd0, 32'd0);
        readback(3'd3);

        // ld and writeback to the same index: writeback wins.
        run_cmd(1, 4'd0, 3'd3, 3'd1, 3'd2, 2, 3'd3, 32'hDEAD_BEEF);
        readback(3'd3);
        chk("coll_same_idx", {32'd0, rd_data1}, {32'd0, 32'h4B9E_3508});
        // Different index: both land.
        run_cmd(1, 4'd0, 3'd3, 3'd1, 3'd2, 2, 3'd7, 32'hDEAD_BEEF);
        readback(3'd7);
        chk("coll_diff_idx", {32'd0, rd_data1}, {32'd0, 32'hDEAD_BEEF});
        // Same-cycle ld into ra is forwarded into the operand.
        run_cmd(1, 4'd0, 3'd5, 3'd1, 3'd2, 0, 3'd1, 32'h0000_0001);
        readback(3'd5);
        chk("ld_bypass_op", {32'd0, rd_data1}, {32'd0, 32'hB4AC_2924});
        // Readback sees a write landing on the same edge.
        ld_en = 1'b1; ld_addr = 3'd6; ld_data = 32'h1234_5678; rd_addr = 3'd6;
        @(negedge clk);
        ld_en = 1'b0;
        set_ref(3'd6, 32'h1234_5678);
        chk("rd_same_edge", {32'd0, rd_data1}, {32'd0, 32'h1234_5678});

        // Randomized commands against the reference model.
        for (int i = 0; i < 8; i++) ld_reg(3'(i), $urandom());
        for (int n = 0; n < 48; n++) begin
            w  = (n % 4 == 3) ? 3 : 1;
            op = 4'($urandom_range(15));
            rd = 3'($urandom_range(7));
            ra = 3'($urandom_range(7));
            rb = 3'($urandom_range(7));
            if ($urandom_range(4) == 0) begin
                op = 4'd1;
                rb = ra;
            end
            case ($urandom_range(3))
                0:       begin lk = -1; la = 3'd0; end
                1:       begin lk = 0;  la = ($urandom_range(1) == 1) ? ra : 3'($urandom_range(7)); end
                2:       begin lk = (w == 1) ? 2 : 4; la = ($urandom_range(1) == 1) ? rd : 3'($urandom_range(7)); end
                default: begin lk = int'($urandom_range((w == 1) ? 2 : 4, 1)); la = 3'($urandom_range(7)); end
            endcase
            run_cmd(w, op, rd, ra, rb, lk, la, $urandom());
            readback(rd);
            if (lk >= 0) readback(la);
        end

        // Reset in WAIT on the ALU_LAT=3 instance: command dropped, everything cleared.
        ld_reg(3'd1, 32'h0000_00A5);
        run_cmd(3, 4'd1, 3'd6, 3'd1, 3'd1, -1, 3'd0, 32'd0);
        chk("pre_rst_zero3", {63'd0, zero_flag3}, 64'd1);
        ld_reg(3'd2, 32'h0000_0003);
        cmd_op = 4'd0; cmd_rd = 3'd4; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_valid3 = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid3 = 1'b0;
        repeat (2) @(negedge clk);
        chk("wait_state_ctl3", {60'd0, ctl_of(3)}, 64'd0);
        resetn = 1'b0;
        #1;
        chk("midrst_ctl3", {60'd0, ctl_of(3)}, 64'd0);
        chk("midrst_misc3", {zero_flag3, alu_op3, alu_a3, 27'd0}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        clear_ref();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("postrst_ctl3_%0d", k), {60'd0, ctl_of(3)}, 64'd1);
        end
        for (int i = 0; i < 8; i++) readback(3'(i));
        chk("postrst_zero3", {63'd0, zero_flag3}, 64'd0);
        ld_reg(3'd1, 32'h0000_0010);
        ld_reg(3'd2, 32'h0000_0020);
        run_cmd(3, 4'd0, 3'd4, 3'd1, 3'd2, -1, 3'd0, 32'd0);
        readback(3'd4);
        chk("postrst_cmd3", {32'd0, rd_data3}, 64'h30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
